// File: rtl/control_ajuste_reloj.sv
// control_ajuste_reloj: PS/2-driven edit-mode sequencer for clock field adjustment.
module control_ajuste_reloj #(
  parameter int N_FIELDS  = 3,
  parameter int TIMEOUT   = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scancode,
  input  logic       got_data,
  output logic       edit_mode,
  output logic [1:0] field,
  output logic       inc,
  output logic       dec,
  output logic       run_en,
  output logic       blink
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  localparam logic [1:0]    F_LAST = 2'(N_FIELDS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
  typedef enum logic {RUN, EDIT} state_t;
  state_t        r_state, w_state;
  logic          r_brk, w_brk;
  logic [1:0]    r_field, w_field;
  logic          r_inc, w_inc, r_dec, w_dec, r_blink, w_blink;
  logic [TW-1:0] r_to, w_to;
  logic [BW-1:0] r_div, w_div;
  logic          w_make, w_key;
  assign w_make = got_data && scancode != 8'hE0 && scancode != 8'hF0 && !r_brk;
  assign w_key  = w_make && (scancode == 8'h74 || scancode == 8'h6B || scancode == 8'h75 ||
                             scancode == 8'h72 || scancode == 8'h5A || scancode == 8'h76);
  always_comb begin
    w_state = r_state;
    w_field = r_field;
    w_inc   = 1'b0;
    w_dec   = 1'b0;
    w_blink = r_blink;
    w_to    = r_to;
    w_div   = r_div;
    w_brk   = !got_data ? r_brk : scancode == 8'hF0 ? 1'b1 : scancode == 8'hE0 ? r_brk : 1'b0;
    if (r_state == RUN) begin
      if (w_make && scancode == 8'h5A) begin
        w_state = EDIT;
        w_field = 2'd0;
      end
    end else if (w_key) begin
      w_to    = '0;
      w_div   = '0;
      w_blink = 1'b1;
      w_inc   = scancode == 8'h75;
      w_dec   = scancode == 8'h72;
      w_field = scancode == 8'h74 ? (r_field == F_LAST ? 2'd0 : r_field + 2'd1) :
                scancode == 8'h6B ? (r_field == 2'd0 ? F_LAST : r_field - 2'd1) : r_field;
      w_state = (scancode == 8'h5A || scancode == 8'h76) ? RUN : EDIT;
    end else begin
      w_to    = r_to + 1'b1;
      w_div   = r_div == B_LAST ? '0 : r_div + 1'b1;
      w_blink = r_div == B_LAST ? ~r_blink : r_blink;
      w_state = r_to == T_LAST ? RUN : EDIT;
    end
    // Both RUN and fresh EDIT entry start with a visible field and cleared counters
    if (w_state == RUN || r_state == RUN) begin
      w_blink = 1'b1;
      w_div   = '0;
      w_to    = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_brk   <= 1'b0;
      r_field <= 2'd0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_blink <= 1'b1;
      r_to    <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state;
      r_brk   <= w_brk;
      r_field <= w_field;
      r_inc   <= w_inc;
      r_dec   <= w_dec;
      r_blink <= w_blink;
      r_to    <= w_to;
      r_div   <= w_div;
    end
  end
  assign edit_mode = r_state == EDIT;
  assign run_en    = r_state != EDIT;
  assign field     = r_field;
  assign inc       = r_inc;
  assign dec       = r_dec;
  assign blink     = r_blink;
endmodule

// File: tb/tb_control_ajuste_reloj.sv
// tb_control_ajuste_reloj: directed plus random scancode stimulus against a behavioural model.
module tb_control_ajuste_reloj;
  localparam int N  = 3;
  localparam int TO = 20;
  localparam int BD = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scancode = 8'h00;
  logic       got_data = 1'b0;
  logic       edit_mode, inc, dec, run_en, blink;
  logic [1:0] field;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_edit, m_brk, m_inc, m_dec;
  int m_field, m_idle;
  logic [7:0] keys [9] = '{8'hE0, 8'hF0, 8'h5A, 8'h74, 8'h6B, 8'h75, 8'h72, 8'h76, 8'h1C};

  control_ajuste_reloj #(.N_FIELDS(N), .TIMEOUT(TO), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .scancode(scancode), .got_data(got_data),
    .edit_mode(edit_mode), .field(field), .inc(inc), .dec(dec),
    .run_en(run_en), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: idle counts EDIT cycles since entry or the last accepted key
  task automatic model(input bit r, input bit gd, input logic [7:0] sc);
    bit make;
    if (r) begin
      m_edit = 0; m_brk = 0; m_inc = 0; m_dec = 0; m_field = 0; m_idle = 0;
      return;
    end
    make = gd && sc != 8'hE0 && sc != 8'hF0 && !m_brk;
    if (gd) m_brk = (sc == 8'hF0) ? 1'b1 : (sc == 8'hE0) ? m_brk : 1'b0;
    m_inc = 0;
    m_dec = 0;
    if (!m_edit) begin
      if (make && sc == 8'h5A) begin
        m_edit = 1; m_field = 0; m_idle = 0;
      end
    end else if (make && sc inside {8'h74, 8'h6B, 8'h75, 8'h72, 8'h5A, 8'h76}) begin
      m_idle = 0;
      case (sc)
        8'h74:   m_field = (m_field + 1) % N;
        8'h6B:   m_field = (m_field + N - 1) % N;
        8'h75:   m_inc = 1;
        8'h72:   m_dec = 1;
        default: m_edit = 0;
      endcase
    end else begin
      m_idle++;
      if (m_idle == TO) m_edit = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit gd, input logic [7:0] sc);
    rst = r;
    got_data = gd;
    scancode = sc;
    model(r, gd, sc);
    @(negedge clk);
    chk("edit_mode", 32'(edit_mode), 32'(m_edit));
    chk("run_en", 32'(run_en), 32'(!m_edit));
    chk("field", 32'(field), 32'(m_field));
    chk("inc", 32'(inc), 32'(m_inc));
    chk("dec", 32'(dec), 32'(m_dec));
    chk("blink", 32'(blink), 32'(!m_edit || ((m_idle / BD) % 2 == 0)));
  endtask

  task automatic key(input logic [7:0] sc);
    cyc(0, 1, sc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00);
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    key(8'h5A); idle(10);
    key(8'h74); key(8'h74); key(8'h74); key(8'h6B);
    key(8'hF0); key(8'h75); key(8'h75); idle(1);
    key(8'hE0); key(8'h72); idle(1);
    key(8'h75); key(8'h75); key(8'h72);
    key(8'h76); idle(2);
    key(8'h75); key(8'h72); key(8'h74); idle(1);
    key(8'h5A); idle(TO + 2);
    key(8'h5A); idle(TO - 1); key(8'h75); idle(TO + 1);
    key(8'h5A); idle(TO - 1); key(8'h76); idle(1);
    key(8'h5A); idle(TO - 1); key(8'h1C); idle(2);
    key(8'h5A); key(8'h74); key(8'h74); key(8'hF0);
    cyc(1, 1, 8'h5A);
    key(8'h5A); idle(3);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) cyc(1, $urandom_range(0, 1) == 1, 8'h5A);
      else if ($urandom_range(0, 59) == 0) idle($urandom_range(TO - 2, TO + 2));
      else if ($urandom_range(0, 9) < 4)
        key($urandom_range(0, 7) == 0 ? 8'($urandom) : keys[$urandom_range(0, 8)]);
      else cyc(0, 0, 8'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
